sd_dac_tx: RTL

First-order delta-sigma modulator (1-bit DAC transmitter), the output-side counterpart of the LVDS comparator digitizer and accumulator path. It accepts WIDTH-bit samples over a valid/ready handshake and holds each one for a frame of 2^OSR_LOG2 clocks. For each sample it emits a 1-bit pulse-density stream on bit_out, which drives an output pin followed by an external RC filter. A one-entry holding buffer lets the producer preload the next sample while the current frame plays.

---
 rtl/sd_dac_pkg.sv | 17 +
 rtl/sd_lfsr16.sv | 19 +
 rtl/sd_dac_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sd_dac_pkg.sv
// Shared definitions for the sd_dac_tx delta-sigma transmitter: state
// encoding, dither LFSR constants and default sizing.
package sd_dac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_OSR_LOG2 = 8;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sd_lfsr16.sv
// 16-bit Fibonacci LFSR with advance enable; supplies dither to sd_dac_tx.
module sd_lfsr16
  import sd_dac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/sd_dac_tx.sv
// First-order delta-sigma 1-bit DAC transmitter with a one-entry holding buffer.
// Define SD_DAC_TX_DITHER_EN to add LFSR carry-in dither to the accumulator.
module sd_dac_tx
  import sd_dac_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned OSR_LOG2 = DEF_OSR_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             underrun_clr,
  output logic             bit_out,
  output logic             frame_strobe,
  output logic             underrun,
  output logic             busy
);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH-1:0]    pend;
  logic                pend_full;
  logic [OSR_LOG2-1:0] frame_cnt;
  logic                frame_end;
  logic                accept;
  logic                load_cur;
  logic                set_underrun;
  logic                dither;
  logic [WIDTH:0]      sum;

`ifdef SD_DAC_TX_DITHER_EN
  logic [15:0] lfsr_q;

  sd_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (state == RUN),
    .q   (lfsr_q)
  );

  assign dither = lfsr_q[0];
`else
  assign dither = 1'b0;
`endif

  assign frame_end    = (frame_cnt == '1);
  assign busy         = (state == RUN);
  assign sample_ready = !pend_full || ((state == RUN) && frame_end && enable);
  assign accept       = sample_valid && sample_ready;
  assign sum          = {1'b0, acc} + {1'b0, cur} + {{WIDTH{1'b0}}, dither};

  always_comb begin
    state_nxt    = state;
    load_cur     = 1'b0;
    set_underrun = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pend_full) begin
          state_nxt = RUN;
          load_cur  = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (pend_full) begin
            load_cur = 1'b1;
          end else begin
            set_underrun = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cur          <= '0;
      pend         <= '0;
      pend_full    <= 1'b0;
      frame_cnt    <= '0;
      bit_out      <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_cur) begin
        cur <= pend;
      end
      // A same-cycle accept refills pend after its old value moved to cur
      if (accept) begin
        pend      <= sample_in;
        pend_full <= 1'b1;
      end else if (load_cur) begin
        pend_full <= 1'b0;
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
      if (state == RUN) begin
        {bit_out, acc} <= sum;
        frame_cnt      <= frame_cnt + OSR_LOG2'(1);
        frame_strobe   <= frame_end;
      end else begin
        acc          <= '0;
        bit_out      <= 1'b0;
        frame_cnt    <= '0;
        frame_strobe <= 1'b0;
      end
    end
  end

endmodule
